led_ctrl_arb: RTL



---
 rtl/led_ctrl_pkg.sv | 28 ++
 rtl/led_ctrl_arb_seq.sv | 81 ++++++++
 rtl/led_ctrl_arb.sv | 110 +++++++++++
 3 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED config-port arbiter and its pattern sequencer.
package led_ctrl_pkg;

    localparam int NUM_PAT_DEF = 4;
    localparam int DWELL_W_DEF = 16;

    localparam logic [7:0] PAT_RST_0 = 8'h5D;
    localparam logic [7:0] PAT_RST_1 = 8'h20;
    localparam logic [7:0] PAT_RST_2 = 8'h10;
    localparam logic [7:0] PAT_RST_3 = 8'h08;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } arb_state_e;

    // Entries beyond the first four reuse the entry-0 pattern.
    function automatic logic [7:0] pat_rst_val(input int idx);
        case (idx)
            1:       return PAT_RST_1;
            2:       return PAT_RST_2;
            3:       return PAT_RST_3;
            default: return PAT_RST_0;
        endcase
    endfunction

endpackage

// File: rtl/led_ctrl_arb_seq.sv
// Pattern sequencer: pattern table, dwell counter, pending flag and the
// index of the next table entry to be written to the LED block.
module led_pat_seq
    import led_ctrl_pkg::*;
#(
    parameter int NUM_PAT = NUM_PAT_DEF,
    parameter int DWELL_W = DWELL_W_DEF,
    localparam int IDX_W  = $clog2(NUM_PAT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               seq_en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               pat_wr,
    input  logic [IDX_W-1:0]   pat_idx,
    input  logic [7:0]         pat_data,
    input  logic               seq_take,
    input  logic               seq_done,
    output logic               seq_pend,
    output logic [IDX_W-1:0]   seq_idx,
    output logic [7:0]         seq_data
);

    logic [7:0]         pat_q [NUM_PAT];
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               expire;

    // Compared against the live dwell value, so a shorter dwell fires at once.
    assign expire = seq_en && (dwell != '0) && (cnt_q >= dwell - DWELL_W'(1));

    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        idx_d  = idx_q;
        if (!seq_en || dwell == '0) begin
            cnt_d = '0;
        end else if (expire) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DWELL_W'(1);
        end
        // Expiry while already pending collapses into the one pending request.
        if (!seq_en) begin
            pend_d = 1'b0;
        end else if (seq_take) begin
            pend_d = expire;
        end else if (expire) begin
            pend_d = 1'b1;
        end
        if (seq_done) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            idx_q  <= '0;
            for (int i = 0; i < NUM_PAT; i++) begin
                pat_q[i] <= pat_rst_val(i);
            end
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            idx_q  <= idx_d;
            if (pat_wr) begin
                pat_q[pat_idx] <= pat_data;
            end
        end
    end

    // Registered table read: a same-cycle pat_wr stores the new value while
    // the old one is still driven.
    assign seq_data = pat_q[idx_q];
    assign seq_pend = pend_q;
    assign seq_idx  = idx_q;

endmodule

// File: rtl/led_ctrl_arb.sv
// Shares the LED block's single config-register port between a host and the
// pattern sequencer using a round-robin IDLE/ACCESS/CAPTURE FSM.
module led_ctrl_arb
    import led_ctrl_pkg::*;
#(
    parameter int NUM_PAT = NUM_PAT_DEF,
    parameter int DWELL_W = DWELL_W_DEF,
    localparam int IDX_W  = $clog2(NUM_PAT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               h_req,
    input  logic               h_we,
    input  logic [7:0]         h_wdata,
    output logic               h_gnt,
    output logic               h_rvalid,
    output logic [7:0]         h_rdata,
    input  logic               seq_en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               pat_wr,
    input  logic [IDX_W-1:0]   pat_idx,
    input  logic [7:0]         pat_data,
    output logic               led_rd_en,
    output logic               led_wr_en,
    output logic [7:0]         led_wdata,
    input  logic [7:0]         led_rdata,
    output logic               busy,
    output logic [IDX_W-1:0]   seq_idx
);

    arb_state_e state_q, state_d;
    logic       acc_host_q, acc_host_d;
    logic       acc_rd_q, acc_rd_d;
    logic       last_host_q, last_host_d;
    logic       h_rvalid_q;
    logic [7:0] h_rdata_q;
    logic       seq_pend, seq_take, seq_done, host_win, in_access;
    logic [7:0] seq_data;

    led_pat_seq #(.NUM_PAT(NUM_PAT), .DWELL_W(DWELL_W)) u_seq (
        .clk      (clk),
        .reset    (reset),
        .seq_en   (seq_en),
        .dwell    (dwell),
        .pat_wr   (pat_wr),
        .pat_idx  (pat_idx),
        .pat_data (pat_data),
        .seq_take (seq_take),
        .seq_done (seq_done),
        .seq_pend (seq_pend),
        .seq_idx  (seq_idx),
        .seq_data (seq_data)
    );

    // Host loses a tie only when it also won the previous access.
    assign host_win = h_req && (!seq_pend || !last_host_q);

    always_comb begin
        state_d     = state_q;
        acc_host_d  = acc_host_q;
        acc_rd_d    = acc_rd_q;
        last_host_d = last_host_q;
        seq_take    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (h_req || seq_pend) begin
                    state_d     = ST_ACCESS;
                    acc_host_d  = host_win;
                    acc_rd_d    = host_win && !h_we;
                    last_host_d = host_win;
                    seq_take    = !host_win;
                end
            end
            ST_ACCESS:  state_d = acc_rd_q ? ST_CAPTURE : ST_IDLE;
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_host_q  <= 1'b0;
            acc_rd_q    <= 1'b0;
            last_host_q <= 1'b0;
            h_rvalid_q  <= 1'b0;
            h_rdata_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            acc_host_q  <= acc_host_d;
            acc_rd_q    <= acc_rd_d;
            last_host_q <= last_host_d;
            h_rvalid_q  <= (state_q == ST_CAPTURE);
            if (state_q == ST_CAPTURE) begin
                h_rdata_q <= led_rdata;
            end
        end
    end

    assign in_access = (state_q == ST_ACCESS);
    assign seq_done  = in_access && !acc_host_q;
    assign h_gnt     = in_access && acc_host_q;
    assign led_rd_en = in_access && acc_rd_q;
    assign led_wr_en = in_access && !acc_rd_q;
    assign led_wdata = led_wr_en ? (acc_host_q ? h_wdata : seq_data) : 8'h00;
    assign h_rvalid  = h_rvalid_q;
    assign h_rdata   = h_rdata_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
